// File: rtl/usb_txn_scheduler.sv
// -----------------------------------------------------------------------------
// usb_txn_scheduler
//
// Host-side transaction scheduler that sits in front of the USB protocol FSM.
// It picks one of NUM_REQ requesters round-robin and issues its IN or OUT
// transaction to the FSM. A failed transaction is retried up to MAX_RETRY
// times. One completion record is returned per transaction over a
// valid/ready port.
//
// Optional feature: define USB_TXN_WATCHDOG_EN to add a WAIT-state watchdog.
// When the watchdog reaches WD_CYCLES, the transaction is reported as failed
// with done_timeout=1 and is not retried.
//
// Ports
//   clk, rst_b      clock and asynchronous active-low reset
//   req_valid       per-requester pending flag
//   req_dir         per-requester direction (1 = IN, 0 = OUT)
//   req_data        per-requester OUT payload, slice i = [64*i +: 64]
//   req_ready       one-hot, 1-cycle accept pulse
//   in_trans        1-cycle start pulse for an IN transaction
//   out_trans       1-cycle start pulse for an OUT transaction
//   data_from_host  OUT payload of the current transaction
//   success         completion pulse from the FSM (ok)
//   failure         completion pulse from the FSM (failed)
//   data_to_host    FSM IN data, valid in the success cycle
//   done_*          completion record (valid/ready handshake)
//   busy            scheduler is not idle
// -----------------------------------------------------------------------------
module usb_txn_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 3,
    parameter int WD_CYCLES = 4096,
    localparam int IDW      = $clog2(NUM_REQ),
    // A retry counter always needs at least one bit, even when MAX_RETRY is 0.
    localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_dir,
    input  logic [NUM_REQ*64-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  in_trans,
    output logic                  out_trans,
    output logic [63:0]           data_from_host,
    input  logic                  success,
    input  logic                  failure,
    input  logic [63:0]           data_to_host,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [IDW-1:0]        done_id,
    output logic                  done_ok,
    output logic [RW-1:0]         done_retries,
    output logic [63:0]           done_data,
    output logic                  done_timeout,
    output logic                  busy
);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("usb_txn_scheduler: NUM_REQ must be >= 2");
    end
    if (MAX_RETRY < 0) begin : g_bad_max_retry
        $error("usb_txn_scheduler: MAX_RETRY must be >= 0");
    end
    if (WD_CYCLES < 1) begin : g_bad_wd_cycles
        $error("usb_txn_scheduler: WD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic                 dir_q, dir_d;
    logic [63:0]          data_q, data_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 in_trans_q, in_trans_d;
    logic                 out_trans_q, out_trans_d;
    logic                 done_valid_q, done_valid_d;
    logic                 done_ok_q, done_ok_d;
    logic [63:0]          done_data_q, done_data_d;
    logic                 done_timeout_q, done_timeout_d;
    logic                 busy_q, busy_d;

`ifdef USB_TXN_WATCHDOG_EN
    localparam int WDW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    logic [WDW-1:0]       wd_cnt_q, wd_cnt_d;
`endif

    // Split the flat payload bus into one 64-bit word per requester.
    logic [63:0] req_slice [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice[g] = req_data[64*g +: 64];
    end

    // Round-robin search: the first valid requester at or after rr_ptr_q wins.
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // NOTE: every signal driven here gets a default value first. Without that,
    // a path that skips the assignment would hold the old value, and the tool
    // would infer a latch.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        dir_d          = dir_q;
        data_d         = data_q;
        retry_d        = retry_q;
        req_ready_d    = '0;
        in_trans_d     = 1'b0;
        out_trans_d    = 1'b0;
        done_valid_d   = done_valid_q;
        done_ok_d      = done_ok_q;
        done_data_d    = done_data_q;
        done_timeout_d = done_timeout_q;
`ifdef USB_TXN_WATCHDOG_EN
        wd_cnt_d       = wd_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready_d[grant_idx] = 1'b1;
                    id_d    = grant_idx;
                    dir_d   = req_dir[grant_idx];
                    data_d  = req_slice[grant_idx];
                    retry_d = '0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                in_trans_d  = dir_q;
                out_trans_d = !dir_q;
`ifdef USB_TXN_WATCHDOG_EN
                wd_cnt_d    = '0;
`endif
                state_d     = S_WAIT;
            end

            S_WAIT: begin
                // If success and failure arrive together, success wins.
                if (success) begin
                    done_ok_d      = 1'b1;
                    done_data_d    = dir_q ? data_to_host : 64'd0;
                    done_timeout_d = 1'b0;
                    done_valid_d   = 1'b1;
                    state_d        = S_REPORT;
                end else if (failure) begin
                    if (retry_q != RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        done_ok_d      = 1'b0;
                        done_data_d    = 64'd0;
                        done_timeout_d = 1'b0;
                        done_valid_d   = 1'b1;
                        state_d        = S_REPORT;
                    end
                end
`ifdef USB_TXN_WATCHDOG_EN
                // On expiry the FSM's state is unknown, so the transaction is
                // reported as failed and is not retried.
                else if (wd_cnt_q == WDW'(WD_CYCLES - 1)) begin
                    done_ok_d      = 1'b0;
                    done_data_d    = 64'd0;
                    done_timeout_d = 1'b1;
                    done_valid_d   = 1'b1;
                    state_d        = S_REPORT;
                end else begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
`endif
            end

            S_REPORT: begin
                // Holding here while the consumer stalls also blocks new grants.
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    rr_ptr_d     = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its value from before the clock edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            dir_q          <= 1'b0;
            data_q         <= '0;
            retry_q        <= '0;
            req_ready_q    <= '0;
            in_trans_q     <= 1'b0;
            out_trans_q    <= 1'b0;
            done_valid_q   <= 1'b0;
            done_ok_q      <= 1'b0;
            done_data_q    <= '0;
            done_timeout_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            dir_q          <= dir_d;
            data_q         <= data_d;
            retry_q        <= retry_d;
            req_ready_q    <= req_ready_d;
            in_trans_q     <= in_trans_d;
            out_trans_q    <= out_trans_d;
            done_valid_q   <= done_valid_d;
            done_ok_q      <= done_ok_d;
            done_data_q    <= done_data_d;
            done_timeout_q <= done_timeout_d;
            busy_q         <= busy_d;
        end
    end

`ifdef USB_TXN_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign req_ready      = req_ready_q;
    assign in_trans       = in_trans_q;
    assign out_trans      = out_trans_q;
    assign data_from_host = data_q;
    assign done_valid     = done_valid_q;
    assign done_id        = id_q;
    assign done_ok        = done_ok_q;
    assign done_retries   = retry_q;
    assign done_data      = done_data_q;
    assign done_timeout   = done_timeout_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_usb_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_usb_txn_scheduler
//
// Directed self-checking bench for usb_txn_scheduler. It uses NUM_REQ=4,
// MAX_RETRY=3 and WD_CYCLES=64. The bench drives the protocol-FSM responses
// inline. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_usb_txn_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int MAX_RETRY = 3;
    localparam int WD_CYCLES = 64;

    logic                  clk;
    logic                  rst_b;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_dir;
    logic [NUM_REQ*64-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  in_trans;
    logic                  out_trans;
    logic [63:0]           data_from_host;
    logic                  success;
    logic                  failure;
    logic [63:0]           data_to_host;
    logic                  done_valid;
    logic                  done_ready;
    logic [1:0]            done_id;
    logic                  done_ok;
    logic [1:0]            done_retries;
    logic [63:0]           done_data;
    logic                  done_timeout;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    usb_txn_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .MAX_RETRY (MAX_RETRY),
        .WD_CYCLES (WD_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .req_valid      (req_valid),
        .req_dir        (req_dir),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .in_trans       (in_trans),
        .out_trans      (out_trans),
        .data_from_host (data_from_host),
        .success        (success),
        .failure        (failure),
        .data_to_host   (data_to_host),
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .done_id        (done_id),
        .done_ok        (done_ok),
        .done_retries   (done_retries),
        .done_data      (done_data),
        .done_timeout   (done_timeout),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond(input int which);
        case (which)
            0:       return |req_ready;
            1:       return in_trans | out_trans;
            default: return done_valid;
        endcase
    endfunction

    // Bounded wait: 0 = any req_ready, 1 = any start pulse, 2 = done_valid.
    task automatic wait_for(input int which, input int budget, input string tag);
        int   n;
        logic hit;
        n   = 0;
        hit = cond(which);
        while (!hit && n < budget) begin
            step();
            n++;
            hit = cond(which);
        end
        check({tag, "_wait"}, 64'(hit), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},    64'(req_ready),    64'd0);
        check({tag, "_in_trans"},     64'(in_trans),     64'd0);
        check({tag, "_out_trans"},    64'(out_trans),    64'd0);
        check({tag, "_data_host"},    data_from_host,    64'd0);
        check({tag, "_done_valid"},   64'(done_valid),   64'd0);
        check({tag, "_done_id"},      64'(done_id),      64'd0);
        check({tag, "_done_ok"},      64'(done_ok),      64'd0);
        check({tag, "_done_retries"}, 64'(done_retries), 64'd0);
        check({tag, "_done_data"},    done_data,         64'd0);
        check({tag, "_done_timeout"}, 64'(done_timeout), 64'd0);
        check({tag, "_busy"},         64'(busy),         64'd0);
    endtask

    // Serve an already-granted OUT transaction: the FSM stub answers success
    // in the same cycle as the start pulse. The payload is id+1 by setup.
    task automatic serve_out(input int exp_id, input string tag);
        wait_for(1, 20, tag);
        check({tag, "_out_trans"}, 64'(out_trans), 64'd1);
        check({tag, "_in_trans"},  64'(in_trans),  64'd0);
        check({tag, "_payload"},   data_from_host, 64'(exp_id + 1));
        success = 1'b1;
        step();
        success = 1'b0;
        check({tag, "_done_valid"}, 64'(done_valid), 64'd1);
        check({tag, "_done_id"},    64'(done_id),    64'(exp_id));
        check({tag, "_done_ok"},    64'(done_ok),    64'd1);
        check({tag, "_done_data"},  done_data,       64'd0);
        step();
        check({tag, "_done_clear"}, 64'(done_valid), 64'd0);
    endtask

    task automatic do_txn_out(input int exp_id, input string tag);
        wait_for(0, 20, tag);
        check({tag, "_grant"}, 64'(req_ready), 64'd1 << exp_id);
        req_valid[exp_id] = 1'b0;
        serve_out(exp_id, tag);
    endtask

    // Answer n_fail failures, then an optional success. Check the record.
    task automatic run_retry(input int exp_id, input int n_fail, input bit finish_ok,
                             input bit is_in, input int exp_retries, input string tag);
        wait_for(0, 20, tag);
        check({tag, "_grant"}, 64'(req_ready), 64'd1 << exp_id);
        req_valid[exp_id] = 1'b0;
        for (int i = 0; i < n_fail; i++) begin
            wait_for(1, 20, {tag, "_fail_pulse"});
            check({tag, "_pulse_dir"}, 64'(in_trans), 64'(is_in));
            failure      = 1'b1;
            data_to_host = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
            failure      = 1'b0;
            data_to_host = 64'd0;
        end
        if (finish_ok) begin
            wait_for(1, 20, {tag, "_ok_pulse"});
            success      = 1'b1;
            data_to_host = 64'h0000_0000_00C0_FFEE;
            step();
            success      = 1'b0;
            data_to_host = 64'd0;
        end
        wait_for(2, 20, {tag, "_done"});
        check({tag, "_done_id"},      64'(done_id),      64'(exp_id));
        check({tag, "_done_ok"},      64'(done_ok),      64'(finish_ok));
        check({tag, "_done_retries"}, 64'(done_retries), 64'(exp_retries));
        check({tag, "_done_data"},    done_data,
              (finish_ok && is_in) ? 64'h0000_0000_00C0_FFEE : 64'd0);
        check({tag, "_done_timeout"}, 64'(done_timeout), 64'd0);
        step();
        check({tag, "_done_clear"}, 64'(done_valid), 64'd0);
    endtask

    initial begin
        int busy_cnt;
        int dv_cnt;
        int n;

        rst_b        = 1'b0;
        req_valid    = '0;
        req_dir      = '0;
        success      = 1'b0;
        failure      = 1'b0;
        data_to_host = 64'd0;
        done_ready   = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_data[64*i +: 64] = 64'(i + 1);

        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst_b = 1'b1;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // Test 1: single IN, success 10 cycles after the start pulse
        req_dir[0]   = 1'b1;
        req_valid[0] = 1'b1;
        wait_for(0, 20, "t1");
        check("t1_grant", 64'(req_ready), 64'b0001);
        check("t1_no_pulse_yet", 64'(in_trans), 64'd0);
        req_valid[0] = 1'b0;
        step();
        check("t1_in_trans", 64'(in_trans), 64'd1);
        check("t1_out_trans", 64'(out_trans), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        step();
        check("t1_pulse_width", 64'(in_trans), 64'd0);
        for (int i = 0; i < 9; i++) step();
        success      = 1'b1;
        data_to_host = 64'hDEAD_BEEF_0123_4567;
        step();
        success      = 1'b0;
        data_to_host = 64'd0;
        check("t1_done_valid",   64'(done_valid),   64'd1);
        check("t1_done_id",      64'(done_id),      64'd0);
        check("t1_done_ok",      64'(done_ok),      64'd1);
        check("t1_done_retries", 64'(done_retries), 64'd0);
        check("t1_done_data",    done_data,         64'hDEAD_BEEF_0123_4567);
        step();
        check("t1_done_clear", 64'(done_valid), 64'd0);
        check("t1_idle",       64'(busy),       64'd0);

        // Reset so the round-robin pointer starts at 0 again
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        step();

        // Test 2: all four OUT requesters pending, then 4'b1010
        req_dir   = '0;
        req_valid = 4'b1111;
        do_txn_out(0, "t2_a0");
        do_txn_out(1, "t2_a1");
        do_txn_out(2, "t2_a2");
        do_txn_out(3, "t2_a3");
        req_valid = 4'b1010;
        do_txn_out(1, "t2_b1");
        do_txn_out(3, "t2_b3");

        // Test 3: retries (OUT recovers after 2 failures; IN exhausts after 4)
        req_valid[2] = 1'b1;
        run_retry(2, 2, 1'b1, 1'b0, 2, "t3_recover");
        req_dir[2]   = 1'b1;
        req_valid[2] = 1'b1;
        run_retry(2, 4, 1'b0, 1'b1, 3, "t3_exhaust");
        req_dir[2]   = 1'b0;

        // Test 4: consumer stall with requester 1 pending; success+failure together
        done_ready   = 1'b0;
        req_dir[0]   = 1'b1;
        req_valid[0] = 1'b1;
        wait_for(0, 20, "t4");
        check("t4_grant", 64'(req_ready), 64'b0001);
        req_valid[0] = 1'b0;
        req_dir[0]   = 1'b0;
        req_valid[1] = 1'b1;
        wait_for(1, 20, "t4_pulse");
        check("t4_in_trans", 64'(in_trans), 64'd1);
        success      = 1'b1;
        failure      = 1'b1;
        data_to_host = 64'h1234_5678_9ABC_DEF0;
        step();
        success      = 1'b0;
        failure      = 1'b0;
        data_to_host = 64'd0;
        check("t4_done_valid", 64'(done_valid), 64'd1);
        check("t4_done_ok",    64'(done_ok),    64'd1);
        check("t4_done_data",  done_data,       64'h1234_5678_9ABC_DEF0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_stall_valid", 64'(done_valid),   64'd1);
            check("t4_stall_id",    64'(done_id),      64'd0);
            check("t4_stall_ok",    64'(done_ok),      64'd1);
            check("t4_stall_retry", 64'(done_retries), 64'd0);
            check("t4_stall_data",  done_data,         64'h1234_5678_9ABC_DEF0);
            check("t4_stall_grant", 64'(req_ready),    64'd0);
        end
        done_ready = 1'b1;
        step();
        check("t4_accepted",      64'(done_valid), 64'd0);
        check("t4_no_early_grant", 64'(req_ready), 64'd0);
        step();
        check("t4_next_grant", 64'(req_ready), 64'b0010);
        req_valid[1] = 1'b0;
        serve_out(1, "t4_r1");

        // Test 5: no FSM response
        req_valid[3] = 1'b1;
        wait_for(0, 20, "t5");
        check("t5_grant", 64'(req_ready), 64'b1000);
        req_valid[3] = 1'b0;
        wait_for(1, 20, "t5_pulse");
`ifdef USB_TXN_WATCHDOG_EN
        n = 0;
        while (!done_valid && n < WD_CYCLES + 20) begin
            step();
            n++;
        end
        check("t5_wd_latency",   64'(n),            64'(WD_CYCLES));
        check("t5_wd_ok",        64'(done_ok),      64'd0);
        check("t5_wd_timeout",   64'(done_timeout), 64'd1);
        check("t5_wd_retries",   64'(done_retries), 64'd0);
        check("t5_wd_data",      done_data,         64'd0);
        check("t5_wd_id",        64'(done_id),      64'd3);
        step();
        check("t5_wd_clear", 64'(done_valid), 64'd0);
        // Start another transaction so that test 6 resets in the middle of WAIT.
        req_valid[3] = 1'b1;
        wait_for(0, 20, "t6_setup");
        req_valid[3] = 1'b0;
        wait_for(1, 20, "t6_setup_pulse");
`else
        busy_cnt = 0;
        dv_cnt   = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (busy) busy_cnt++;
            if (done_valid) dv_cnt++;
        end
        check("t5_busy_hold",  64'(busy_cnt), 64'd10000);
        check("t5_no_done",    64'(dv_cnt),   64'd0);
`endif

        // Test 6: asynchronous reset in the middle of WAIT
        step();
        step();
        check("t6_pre_busy", 64'(busy), 64'd1);
        rst_b = 1'b0;
        #1;
        check_all_zero("t6_reset");
        step();
        rst_b = 1'b1;
        // A completion pulse outside WAIT must be ignored.
        success = 1'b1;
        step();
        success = 1'b0;
        check("t6_ignored_done", 64'(done_valid), 64'd0);
        check("t6_ignored_busy", 64'(busy),       64'd0);
        step();
        check("t6_no_record", 64'(done_valid), 64'd0);
        req_valid = 4'b0110;
        do_txn_out(1, "t6_r1");
        do_txn_out(2, "t6_r2");
        step();
        check("t6_final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
